alu_control_seq: RTL

Parametrised, registered successor to the combinational ALU control decoder for the multi-cycle/pipelined core.
- Decodes {funct7, ALU_Op, funct3} into an ALU operation code, extended with SRA/SLT/SLTU/BLTU/BGEU and the RV32M ops.
- Wraps decode in a valid/ready handshake with one output register stage.
- Sequences multi-cycle MUL/DIV/REM ops by launching the MDU and stalling the issue stage until done.
- Sits between the main control unit and the ALU/MDU in the execute stage.

---
 rtl/alu_control_pkg.sv | 50 +++++
 rtl/alu_decode_comb.sv | 103 ++++++++++
 rtl/alu_control_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_control_pkg.sv
// Shared encodings for the execute-stage ALU control: ALU_Op classes, funct7 patterns,
// 5-bit base operation codes and the sequencer state encoding.
package alu_control_pkg;

    localparam logic [2:0] AOP_R   = 3'b000;
    localparam logic [2:0] AOP_I   = 3'b001;
    localparam logic [2:0] AOP_U   = 3'b010;
    localparam logic [2:0] AOP_B   = 3'b011;
    localparam logic [2:0] AOP_S   = 3'b100;
    localparam logic [2:0] AOP_LD  = 3'b101;
    localparam logic [2:0] AOP_JAL = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_LUI    = 5'b00001;
    localparam logic [4:0] OP_OR     = 5'b00010;
    localparam logic [4:0] OP_SLL    = 5'b00011;
    localparam logic [4:0] OP_SRL    = 5'b00100;
    localparam logic [4:0] OP_SUB    = 5'b00101;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_BEQ    = 5'b01001;
    localparam logic [4:0] OP_BNE    = 5'b01010;
    localparam logic [4:0] OP_BLT    = 5'b01011;
    localparam logic [4:0] OP_BGE    = 5'b01100;
    localparam logic [4:0] OP_JAL    = 5'b01101;
    localparam logic [4:0] OP_SRA    = 5'b01110;
    localparam logic [4:0] OP_SLT    = 5'b01111;
    localparam logic [4:0] OP_SLTU   = 5'b10111;
    localparam logic [4:0] OP_BLTU   = 5'b11000;
    localparam logic [4:0] OP_BGEU   = 5'b11001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b11010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_MDU  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational selector {funct7, alu_op, funct3} -> {op, illegal, is_mdu}.
// Anything that matches no legal encoding reports illegal and decodes to ADD.
module alu_decode_comb
    import alu_control_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int M_EXT = 1
) (
    input  logic [6:0]      funct7,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
    output logic [OP_W-1:0] op,
    output logic            illegal,
    output logic            is_mdu
);

    logic [4:0] code;
    logic       ill;
    logic       mdu;

    always_comb begin
        code = OP_ADD;
        ill  = 1'b0;
        mdu  = 1'b0;
        case (alu_op)
            AOP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  code = OP_ADD;
                        3'b001:  code = OP_SLL;
                        3'b010:  code = OP_SLT;
                        3'b011:  code = OP_SLTU;
                        3'b100:  code = OP_XOR;
                        3'b101:  code = OP_SRL;
                        3'b110:  code = OP_OR;
                        default: code = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    code = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    code = OP_SRA;
                end else if (funct7 == F7_MEXT && M_EXT != 0) begin
                    mdu = 1'b1;
                    case (funct3)
                        3'b000:  code = OP_MUL;
                        3'b001:  code = OP_MULH;
                        3'b010:  code = OP_MULHSU;
                        3'b011:  code = OP_MULHU;
                        3'b100:  code = OP_DIV;
                        3'b101:  code = OP_DIVU;
                        3'b110:  code = OP_REM;
                        default: code = OP_REMU;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            AOP_I: begin
                // funct7 is immediate bits except for the shift forms
                case (funct3)
                    3'b000:  code = OP_ADD;
                    3'b010:  code = OP_SLT;
                    3'b011:  code = OP_SLTU;
                    3'b100:  code = OP_XOR;
                    3'b110:  code = OP_OR;
                    3'b111:  code = OP_AND;
                    3'b001:  begin
                        code = OP_SLL;
                        ill  = (funct7 != F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE)     code = OP_SRL;
                        else if (funct7 == F7_ALT) code = OP_SRA;
                        else                       ill  = 1'b1;
                    end
                endcase
            end
            AOP_U:   code = OP_LUI;
            AOP_B: begin
                case (funct3)
                    3'b000:  code = OP_BEQ;
                    3'b001:  code = OP_BNE;
                    3'b100:  code = OP_BLT;
                    3'b101:  code = OP_BGE;
                    3'b110:  code = OP_BLTU;
                    3'b111:  code = OP_BGEU;
                    default: ill  = 1'b1;
                endcase
            end
            AOP_S, AOP_LD: begin
                code = OP_ADD;
                ill  = (funct3 != 3'b010);
            end
            AOP_JAL: code = OP_JAL;
            default: ill  = 1'b1;
        endcase
    end

    assign op      = ill ? OP_W'(OP_ADD) : OP_W'(code);
    assign illegal = ill;
    assign is_mdu  = mdu & ~ill;

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with valid/ready handshake; M ops launch the MDU and
// stall issue for MDU_CYCLES cycles before the result code is presented.
module alu_control_seq
    import alu_control_pkg::*;
#(
    parameter int OP_W       = 5,
    parameter int M_EXT      = 1,
    parameter int MDU_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [OP_W-1:0] alu_operation_o,
    output logic            illegal_o,
    output logic            mdu_start_o,
    output logic            mdu_busy_o
);

    localparam int CNT_W = $clog2(MDU_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  dec_op;
    logic             dec_illegal;
    logic             dec_mdu;
    logic             accept;

    alu_decode_comb #(
        .OP_W  (OP_W),
        .M_EXT (M_EXT)
    ) u_decode (
        .funct7  (funct7_i),
        .alu_op  (alu_op_i),
        .funct3  (funct3_i),
        .op      (dec_op),
        .illegal (dec_illegal),
        .is_mdu  (dec_mdu)
    );

    assign ready_o = (state == S_IDLE) || (state == S_HOLD && ready_i);
    assign accept  = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            valid_o         <= 1'b0;
            illegal_o       <= 1'b0;
            mdu_start_o     <= 1'b0;
            mdu_busy_o      <= 1'b0;
            alu_operation_o <= '0;
        end else if (flush_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            mdu_start_o <= 1'b0;
            mdu_busy_o  <= 1'b0;
        end else begin
            mdu_start_o <= 1'b0;
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        alu_operation_o <= dec_op;
                        illegal_o       <= dec_illegal;
                        if (dec_mdu) begin
                            state       <= S_MDU;
                            valid_o     <= 1'b0;
                            mdu_start_o <= 1'b1;
                            mdu_busy_o  <= 1'b1;
                            cnt         <= CNT_W'(MDU_CYCLES - 1);
                        end else begin
                            state   <= S_HOLD;
                            valid_o <= 1'b1;
                        end
                    end else if (state == S_HOLD && ready_i) begin
                        state   <= S_IDLE;
                        valid_o <= 1'b0;
                    end
                end
                S_MDU: begin
                    // counter reaching 0 ends the busy window; it never wraps
                    if (cnt == '0) begin
                        state      <= S_HOLD;
                        valid_o    <= 1'b1;
                        mdu_busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
